binary_to_bcd: RTL and testbench



---
 rtl/bcd_pkg.sv | 15 +
 rtl/bcd_add3.sv | 10 +
 rtl/binary_to_bcd.sv | 64 ++++++
 tb/tb_binary_to_bcd.sv | 132 +++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the
// binary-to-BCD converter.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  // Number of decimal digits in the value 2^n, i.e. ceil(log10(2^n)).
  // Scaled-integer log10(2) keeps this a constant function.
  function automatic int bcd_digits(input int n);
    longint unsigned p;
    p = 64'(n) * 64'd301029995664;
    return int'(p / 64'd1000000000000) + 1;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell:
// add 3 to a nibble of 5 or more.
module bcd_add3 (
  input  logic [3:0] in,
  output logic [3:0] out
);

  assign out = (in >= 4'd5) ? in + 4'd3 : in;

endmodule

// File: rtl/binary_to_bcd.sv
// Unrolled shift-and-add-3 converter
// with a registered packed-BCD output.
module binary_to_bcd
  import bcd_pkg::*;
#(
  parameter int bin = 4,
  parameter int bcd = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [bin-1:0] binary,
  output logic [bcd-1:0] BCD
);

  localparam int ND = bcd_digits(bin);
  localparam int D  = bcd / BCD_DIGIT_W;
  localparam int W  = bcd + bin;

  if (bin < 1) begin : g_chk_bin
    $error("binary_to_bcd: bin must be >= 1");
  end

  if ((bcd % BCD_DIGIT_W) != 0 ||
      bcd < BCD_DIGIT_W * ND) begin : g_chk_bcd
    $error("binary_to_bcd: illegal bcd width");
  end

  logic [W-1:0]   stg [0:bin];
  logic [W-1:0]   adj [0:bin-1];
  logic [bin-1:0] drop;
  logic [bcd-1:0] res;
  logic           unused_bits;

  assign stg[0] = {{bcd{1'b0}}, binary};

  for (genvar i = 0; i < bin; i++) begin : g_it
    assign adj[i][bin-1:0] = stg[i][bin-1:0];
    for (genvar d = 0; d < D; d++) begin : g_dig
      bcd_add3 u_add3 (
        .in  (stg[i][bin+4*d +: 4]),
        .out (adj[i][bin+4*d +: 4])
      );
    end
    assign stg[i+1] = {adj[i][W-2:0], 1'b0};
    assign drop[i]  = adj[i][W-1];
  end

  // Digits beyond the reach of a bin-bit value are tied off.
  for (genvar d = 0; d < D; d++) begin : g_out
    if (d < ND) begin : g_live
      assign res[4*d +: 4] = stg[bin][bin+4*d +: 4];
    end else begin : g_tie
      assign res[4*d +: 4] = 4'd0;
    end
  end

  assign unused_bits = ^{stg[bin], drop};

  always_ff @(posedge clk) begin
    if (reset) BCD <= '0;
    else       BCD <= res;
  end

endmodule

// File: tb/tb_binary_to_bcd.sv
// Self-checking bench for binary_to_bcd:
// vector table plus a randomized wide build.
module tb_binary_to_bcd;

  typedef struct {
    logic       rst;
    logic [3:0] val;
    logic [7:0] exp;
  } vec_t;

  logic        clk = 0;
  logic        reset;
  logic [3:0]  binary;
  logic [7:0]  BCD;
  logic        rst_w;
  logic [7:0]  bin_w;
  logic [11:0] bcd_w;

  int checks = 0;
  int errors = 0;

  vec_t tbl[$];

  always #5 clk = ~clk;

  binary_to_bcd #(.bin(4), .bcd(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .binary (binary),
    .BCD    (BCD)
  );

  binary_to_bcd #(.bin(8), .bcd(12)) dut_w (
    .clk    (clk),
    .reset  (rst_w),
    .binary (bin_w),
    .BCD    (bcd_w)
  );

  function automatic logic [11:0] ref_bcd(int v);
    logic [11:0] r = '0;
    for (int k = 0; k < 3; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] ref8(int v);
    logic [11:0] r = ref_bcd(v);
    return r[7:0];
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wide(int v);
    logic [11:0] e;
    bin_w = 8'(v);
    tick();
    e = ref_bcd(v);
    chk($sformatf("wide_%0d", v), 32'(bcd_w), 32'(e));
    for (int k = 0; k < 3; k++)
      if (bcd_w[4*k +: 4] > 4'd9) begin
        checks++;
        errors++;
        $display("FAIL digit_range: got %0h nibble %0d",
                 bcd_w, k);
      end
  endtask

  initial begin
    reset  = 1;
    binary = 4'hF;
    rst_w  = 1;
    bin_w  = 8'hFF;

    for (int i = 0; i < 3; i++)
      tbl.push_back('{1'b1, 4'hF, 8'h00});
    tbl.push_back('{1'b0, 4'hF, 8'h15});
    for (int i = 0; i < 16; i++)
      tbl.push_back('{1'b0, 4'(i), ref8(i)});
    tbl.push_back('{1'b0, 4'd9, 8'h09});
    tbl.push_back('{1'b0, 4'd10, 8'h10});
    tbl.push_back('{1'b0, 4'd12, 8'h12});
    tbl.push_back('{1'b1, 4'd12, 8'h00});
    tbl.push_back('{1'b0, 4'd12, 8'h12});

    for (int i = 0; i < tbl.size(); i++) begin
      reset  = tbl[i].rst;
      binary = tbl[i].val;
      tick();
      chk($sformatf("vec%0d_in%0d", i, tbl[i].val),
          32'(BCD), 32'(tbl[i].exp));
    end

    // Back-to-back changes: each value lands one edge later.
    binary = 4'd3;
    tick();
    binary = 4'd14;
    chk("b2b_hold", 32'(BCD), 32'h03);
    tick();
    chk("b2b_next", 32'(BCD), 32'h14);

    tick();
    chk("wide_reset", 32'(bcd_w), 32'h000);
    rst_w = 0;
    wide(0);
    wide(99);
    wide(100);
    wide(255);
    for (int i = 0; i < 200; i++)
      wide(int'($urandom_range(0, 255)));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
